// File: rtl/axi_lite_arbiter.sv
// axi_lite_arbiter: round-robin 2:1 AXI-lite arbiter (IFU read-only, LSU read/write) in front of one slave
module axi_lite_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                m0_ar_valid_i,
  input  logic [ADDR_W-1:0]   m0_ar_addr_i,
  output logic                m0_ar_ready_o,
  output logic                m0_r_valid_o,
  output logic [DATA_W-1:0]   m0_r_data_o,
  output logic [1:0]          m0_r_resp_o,
  input  logic                m0_r_ready_i,
  input  logic                m1_ar_valid_i,
  input  logic [ADDR_W-1:0]   m1_ar_addr_i,
  output logic                m1_ar_ready_o,
  output logic                m1_r_valid_o,
  output logic [DATA_W-1:0]   m1_r_data_o,
  output logic [1:0]          m1_r_resp_o,
  input  logic                m1_r_ready_i,
  input  logic                m1_aw_valid_i,
  input  logic [ADDR_W-1:0]   m1_aw_addr_i,
  output logic                m1_aw_ready_o,
  input  logic                m1_w_valid_i,
  input  logic [DATA_W-1:0]   m1_w_data_i,
  input  logic [DATA_W/8-1:0] m1_w_strb_i,
  output logic                m1_w_ready_o,
  output logic                m1_b_valid_o,
  output logic [1:0]          m1_b_resp_o,
  input  logic                m1_b_ready_i,
  output logic                s_ar_valid_o,
  output logic [ADDR_W-1:0]   s_ar_addr_o,
  input  logic                s_ar_ready_i,
  input  logic                s_r_valid_i,
  input  logic [DATA_W-1:0]   s_r_data_i,
  input  logic [1:0]          s_r_resp_i,
  output logic                s_r_ready_o,
  output logic                s_aw_valid_o,
  output logic [ADDR_W-1:0]   s_aw_addr_o,
  input  logic                s_aw_ready_i,
  output logic                s_w_valid_o,
  output logic [DATA_W-1:0]   s_w_data_o,
  output logic [DATA_W/8-1:0] s_w_strb_o,
  input  logic                s_w_ready_i,
  input  logic                s_b_valid_i,
  input  logic [1:0]          s_b_resp_i,
  output logic                s_b_ready_o
);
  typedef enum logic [3:0] {
    IDLE      = 4'b0001,
    GNT_M0_RD = 4'b0010,
    GNT_M1_RD = 4'b0100,
    GNT_M1_WR = 4'b1000
  } state_t;
  state_t r_state;
  logic   r_last;
  logic   w_g0, w_g1r, w_g1w, w_req0, w_req1, w_pick0;
  assign w_g0    = r_state == GNT_M0_RD;
  assign w_g1r   = r_state == GNT_M1_RD;
  assign w_g1w   = r_state == GNT_M1_WR;
  assign w_req0  = m0_ar_valid_i;
  assign w_req1  = m1_ar_valid_i | m1_aw_valid_i;
  // r_last high means M1 was granted last, so M0 wins a tie
  assign w_pick0 = w_req0 & (~w_req1 | r_last);
  always_ff @(posedge clk_i)
    if (rst_i) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
    end else
      case (r_state)
        IDLE: if (w_req0 | w_req1) begin
          r_state <= w_pick0 ? GNT_M0_RD : m1_ar_valid_i ? GNT_M1_RD : GNT_M1_WR;
          r_last  <= ~w_pick0;
        end
        GNT_M0_RD: if (s_r_valid_i & m0_r_ready_i) r_state <= IDLE;
        GNT_M1_RD: if (s_r_valid_i & m1_r_ready_i) r_state <= IDLE;
        GNT_M1_WR: if (s_b_valid_i & m1_b_ready_i) r_state <= IDLE;
        default:   r_state <= IDLE;
      endcase
  assign s_ar_valid_o  = (w_g0 & m0_ar_valid_i) | (w_g1r & m1_ar_valid_i);
  assign s_ar_addr_o   = w_g1r ? m1_ar_addr_i : m0_ar_addr_i;
  assign s_r_ready_o   = (w_g0 & m0_r_ready_i) | (w_g1r & m1_r_ready_i);
  assign s_aw_valid_o  = w_g1w & m1_aw_valid_i;
  assign s_aw_addr_o   = m1_aw_addr_i;
  assign s_w_valid_o   = w_g1w & m1_w_valid_i;
  assign s_w_data_o    = m1_w_data_i;
  assign s_w_strb_o    = m1_w_strb_i;
  assign s_b_ready_o   = w_g1w & m1_b_ready_i;
  assign m0_ar_ready_o = w_g0 & s_ar_ready_i;
  assign m0_r_valid_o  = w_g0 & s_r_valid_i;
  assign m0_r_data_o   = s_r_data_i;
  assign m0_r_resp_o   = s_r_resp_i;
  assign m1_ar_ready_o = w_g1r & s_ar_ready_i;
  assign m1_r_valid_o  = w_g1r & s_r_valid_i;
  assign m1_r_data_o   = s_r_data_i;
  assign m1_r_resp_o   = s_r_resp_i;
  assign m1_aw_ready_o = w_g1w & s_aw_ready_i;
  assign m1_w_ready_o  = w_g1w & s_w_ready_i;
  assign m1_b_valid_o  = w_g1w & s_b_valid_i;
  assign m1_b_resp_o   = s_b_resp_i;
endmodule

// File: tb/tb_axi_lite_arbiter.sv
// tb_axi_lite_arbiter: randomized rounds of concurrent master requests against a behavioural slave,
// checked against a transaction-level round-robin model and a reference memory.
module tb_axi_lite_arbiter;
  logic        clk_i, rst_i;
  logic        m0_ar_valid_i, m0_ar_ready_o, m0_r_valid_o, m0_r_ready_i;
  logic [31:0] m0_ar_addr_i, m0_r_data_o;
  logic [1:0]  m0_r_resp_o;
  logic        m1_ar_valid_i, m1_ar_ready_o, m1_r_valid_o, m1_r_ready_i;
  logic [31:0] m1_ar_addr_i, m1_r_data_o;
  logic [1:0]  m1_r_resp_o;
  logic        m1_aw_valid_i, m1_aw_ready_o, m1_w_valid_i, m1_w_ready_o;
  logic [31:0] m1_aw_addr_i, m1_w_data_i;
  logic [3:0]  m1_w_strb_i;
  logic        m1_b_valid_o, m1_b_ready_i;
  logic [1:0]  m1_b_resp_o;
  logic        s_ar_valid_o, s_ar_ready_i, s_r_valid_i, s_r_ready_o;
  logic [31:0] s_ar_addr_o, s_r_data_i;
  logic [1:0]  s_r_resp_i;
  logic        s_aw_valid_o, s_aw_ready_i, s_w_valid_o, s_w_ready_i, s_b_valid_i, s_b_ready_o;
  logic [31:0] s_aw_addr_o, s_w_data_o;
  logic [3:0]  s_w_strb_o;
  logic [1:0]  s_b_resp_i;

  axi_lite_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_ar_valid_i(m0_ar_valid_i), .m0_ar_addr_i(m0_ar_addr_i), .m0_ar_ready_o(m0_ar_ready_o),
    .m0_r_valid_o(m0_r_valid_o), .m0_r_data_o(m0_r_data_o), .m0_r_resp_o(m0_r_resp_o),
    .m0_r_ready_i(m0_r_ready_i),
    .m1_ar_valid_i(m1_ar_valid_i), .m1_ar_addr_i(m1_ar_addr_i), .m1_ar_ready_o(m1_ar_ready_o),
    .m1_r_valid_o(m1_r_valid_o), .m1_r_data_o(m1_r_data_o), .m1_r_resp_o(m1_r_resp_o),
    .m1_r_ready_i(m1_r_ready_i),
    .m1_aw_valid_i(m1_aw_valid_i), .m1_aw_addr_i(m1_aw_addr_i), .m1_aw_ready_o(m1_aw_ready_o),
    .m1_w_valid_i(m1_w_valid_i), .m1_w_data_i(m1_w_data_i), .m1_w_strb_i(m1_w_strb_i),
    .m1_w_ready_o(m1_w_ready_o),
    .m1_b_valid_o(m1_b_valid_o), .m1_b_resp_o(m1_b_resp_o), .m1_b_ready_i(m1_b_ready_i),
    .s_ar_valid_o(s_ar_valid_o), .s_ar_addr_o(s_ar_addr_o), .s_ar_ready_i(s_ar_ready_i),
    .s_r_valid_i(s_r_valid_i), .s_r_data_i(s_r_data_i), .s_r_resp_i(s_r_resp_i),
    .s_r_ready_o(s_r_ready_o),
    .s_aw_valid_o(s_aw_valid_o), .s_aw_addr_o(s_aw_addr_o), .s_aw_ready_i(s_aw_ready_i),
    .s_w_valid_o(s_w_valid_o), .s_w_data_o(s_w_data_o), .s_w_strb_o(s_w_strb_o),
    .s_w_ready_i(s_w_ready_i),
    .s_b_valid_i(s_b_valid_i), .s_b_resp_i(s_b_resp_i), .s_b_ready_o(s_b_ready_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_chk = 0, n_pass = 0, cyc = 0;
  bit last_m1 = 1'b1;
  logic [31:0] ref_mem [16];
  int log_q[$], cyc_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic logic [31:0] init_val(input int i);
    return {i[7:0], 8'hA5, 8'(i * 3), 8'h3C};
  endfunction

  // behavioural slave: always-ready address/data, 0..2 cycle response latency
  assign s_ar_ready_i = 1'b1;
  assign s_aw_ready_i = 1'b1;
  assign s_w_ready_i  = 1'b1;
  logic [31:0] smem [16];
  logic        rp, bp, awg, wg;
  int          rcnt, bcnt;
  logic [3:0]  ridx, widx, wsb;
  logic [31:0] wd;
  always @(posedge clk_i) begin
    cyc <= cyc + 1;
    if (rst_i) begin
      s_r_valid_i <= 1'b0;
      s_b_valid_i <= 1'b0;
      rp <= 1'b0; bp <= 1'b0; awg <= 1'b0; wg <= 1'b0;
      for (int i = 0; i < 16; i++) smem[i] <= init_val(i);
    end else begin
      if (s_r_valid_i && s_r_ready_o) s_r_valid_i <= 1'b0;
      if (rp) begin
        if (rcnt == 0) begin
          s_r_valid_i <= 1'b1; s_r_data_i <= smem[ridx]; s_r_resp_i <= ridx[1:0]; rp <= 1'b0;
        end else rcnt <= rcnt - 1;
      end
      if (s_ar_valid_o) begin
        rp <= 1'b1; rcnt <= $urandom_range(0, 2); ridx <= s_ar_addr_o[5:2];
        log_q.push_back(int'(s_ar_addr_o[9:8])); cyc_q.push_back(cyc);
      end
      if (awg && wg) begin
        for (int b = 0; b < 4; b++) if (wsb[b]) smem[widx][8*b +: 8] <= wd[8*b +: 8];
        awg <= 1'b0; wg <= 1'b0; bp <= 1'b1; bcnt <= $urandom_range(0, 2);
      end
      if (s_b_valid_i && s_b_ready_o) s_b_valid_i <= 1'b0;
      if (bp) begin
        if (bcnt == 0) begin
          s_b_valid_i <= 1'b1; s_b_resp_i <= ~widx[1:0]; bp <= 1'b0;
        end else bcnt <= bcnt - 1;
      end
      if (s_aw_valid_o) begin
        awg <= 1'b1; widx <= s_aw_addr_o[5:2];
        log_q.push_back(int'(s_aw_addr_o[9:8])); cyc_q.push_back(cyc);
      end
      if (s_w_valid_o) begin
        wg <= 1'b1; wd <= s_w_data_o; wsb <= s_w_strb_o;
      end
    end
  end

  // at most one master may see activity, and a read grant never forwards the write channels
  logic w_a0, w_a1;
  logic [11:0] w_outs;
  assign w_a0 = m0_ar_ready_o | m0_r_valid_o;
  assign w_a1 = m1_ar_ready_o | m1_r_valid_o | m1_aw_ready_o | m1_w_ready_o | m1_b_valid_o;
  assign w_outs = {m0_ar_ready_o, m0_r_valid_o, m1_ar_ready_o, m1_r_valid_o, m1_aw_ready_o,
                   m1_w_ready_o, m1_b_valid_o, s_ar_valid_o, s_r_ready_o, s_aw_valid_o,
                   s_w_valid_o, s_b_ready_o};
  always @(negedge clk_i)
    if (!rst_i && (w_a0 || w_a1))
      chk("excl", {30'd0, w_a0 & w_a1,
                   (s_ar_valid_o | s_r_ready_o) & (s_aw_valid_o | s_w_valid_o | s_b_ready_o)}, 32'd0);

  task automatic rd(input bit m);
    int n;
    logic [3:0] i;
    i = m ? m1_ar_addr_i[5:2] : m0_ar_addr_i[5:2];
    n = 0;
    while (!(m ? m1_ar_ready_o : m0_ar_ready_o) && n < 300) begin @(negedge clk_i); n++; end
    chk("rd_ar_tmo", {31'd0, n < 300}, 32'd1);
    @(posedge clk_i); #1;
    if (m) m1_ar_valid_i = 1'b0; else m0_ar_valid_i = 1'b0;
    repeat ($urandom_range(0, 2)) @(posedge clk_i);
    #1;
    if (m) m1_r_ready_i = 1'b1; else m0_r_ready_i = 1'b1;
    @(negedge clk_i);
    n = 0;
    while (!(m ? m1_r_valid_o : m0_r_valid_o) && n < 300) begin @(negedge clk_i); n++; end
    chk("rdata", m ? m1_r_data_o : m0_r_data_o, ref_mem[i]);
    chk("rresp", {30'd0, m ? m1_r_resp_o : m0_r_resp_o}, {30'd0, i[1:0]});
    @(posedge clk_i); #1;
    if (m) m1_r_ready_i = 1'b0; else m0_r_ready_i = 1'b0;
  endtask

  task automatic wr();
    int n;
    logic [3:0] i;
    logic [31:0] d;
    logic [3:0] s;
    i = m1_aw_addr_i[5:2]; d = m1_w_data_i; s = m1_w_strb_i;
    n = 0;
    while (!(m1_aw_ready_o && m1_w_ready_o) && n < 300) begin @(negedge clk_i); n++; end
    chk("wr_aw_tmo", {31'd0, n < 300}, 32'd1);
    @(posedge clk_i); #1;
    m1_aw_valid_i = 1'b0; m1_w_valid_i = 1'b0;
    repeat ($urandom_range(0, 2)) @(posedge clk_i);
    #1;
    m1_b_ready_i = 1'b1;
    @(negedge clk_i);
    n = 0;
    while (!m1_b_valid_o && n < 300) begin @(negedge clk_i); n++; end
    chk("bresp", {30'd0, m1_b_resp_o}, {30'd0, ~i[1:0]});
    for (int b = 0; b < 4; b++) if (s[b]) ref_mem[i][8*b +: 8] = d[8*b +: 8];
    @(posedge clk_i); #1;
    m1_b_ready_i = 1'b0;
  endtask

  // tags in the address: bits [9:8] = 0 m0 read, 1 m1 read, 2 m1 write
  task automatic round(input bit r0, input bit r1, input bit w1, input logic [3:0] i0,
                       input logic [3:0] i1, input logic [3:0] iw, input logic [31:0] wdat,
                       input logic [3:0] ws);
    int exp_q[$];
    int start;
    bit p0, p1, pw;
    p0 = r0; p1 = r1; pw = w1;
    while (p0 || p1 || pw) begin
      if (p0 && (!(p1 || pw) || last_m1)) begin
        exp_q.push_back(0); p0 = 0; last_m1 = 0;
      end else begin
        exp_q.push_back(p1 ? 1 : 2);
        if (p1) p1 = 0; else pw = 0;
        last_m1 = 1;
      end
    end
    log_q.delete(); cyc_q.delete();
    m0_ar_valid_i = r0; m0_ar_addr_i = 32'h8000_0000 | {26'd0, i0, 2'b00};
    m1_ar_valid_i = r1; m1_ar_addr_i = 32'h8000_0100 | {26'd0, i1, 2'b00};
    m1_aw_valid_i = w1; m1_aw_addr_i = 32'h8000_0200 | {26'd0, iw, 2'b00};
    m1_w_valid_i  = w1; m1_w_data_i = wdat; m1_w_strb_i = ws;
    start = cyc;
    @(negedge clk_i);
    chk("idle_quiet", {20'd0, w_outs}, 32'd0);
    fork
      if (r0) rd(1'b0);
      if (r1) rd(1'b1);
      if (w1) wr();
    join
    chk("n_txn", log_q.size(), exp_q.size());
    foreach (exp_q[k]) chk("order", k < log_q.size() ? log_q[k] : -1, exp_q[k]);
    if (cyc_q.size() > 0) chk("grant_lat", cyc_q[0], start + 1);
  endtask

  initial begin
    int n;
    bit r0, r1, w1;
    for (int i = 0; i < 16; i++) ref_mem[i] = init_val(i);
    rst_i = 1'b1;
    {m0_ar_valid_i, m0_r_ready_i, m1_ar_valid_i, m1_r_ready_i} = '0;
    {m1_aw_valid_i, m1_w_valid_i, m1_b_ready_i} = '0;
    m0_ar_addr_i = '0; m1_ar_addr_i = '0; m1_aw_addr_i = '0; m1_w_data_i = '0; m1_w_strb_i = '0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    chk("rst_quiet", {20'd0, w_outs}, 32'd0);
    @(posedge clk_i); #1;
    round(1, 1, 0, 4'd1, 4'd2, 4'd0, 32'd0, 4'd0);
    round(1, 1, 0, 4'd3, 4'd5, 4'd0, 32'd0, 4'd0);
    round(1, 0, 0, 4'd0, 4'd0, 4'd0, 32'd0, 4'd0);
    round(0, 0, 1, 4'd0, 4'd0, 4'd4, 32'hDEADBEEF, 4'hF);
    round(0, 1, 0, 4'd0, 4'd4, 4'd0, 32'd0, 4'd0);
    round(1, 0, 0, 4'd7, 4'd0, 4'd0, 32'd0, 4'd0);
    round(1, 0, 1, 4'd4, 4'd0, 4'd9, 32'h1234_5678, 4'h5);
    round(0, 1, 1, 4'd0, 4'd9, 4'd9, 32'hCAFE_F00D, 4'hA);
    for (int k = 0; k < 40; k++) begin
      r0 = 1'($urandom_range(0, 1)); r1 = 1'($urandom_range(0, 1)); w1 = 1'($urandom_range(0, 1));
      if (!(r0 || r1 || w1)) r0 = 1'b1;
      round(r0, r1, w1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), $urandom, 4'($urandom_range(1, 15)));
      repeat ($urandom_range(0, 2)) begin @(posedge clk_i); #1; end
    end
    // reset while a write is waiting for its B handshake
    m1_b_ready_i = 1'b0;
    m1_aw_valid_i = 1'b1; m1_w_valid_i = 1'b1;
    m1_aw_addr_i = 32'h8000_0208; m1_w_data_i = 32'h0BAD_0BAD; m1_w_strb_i = 4'hF;
    @(negedge clk_i);
    n = 0;
    while (!m1_aw_ready_o && n < 300) begin @(negedge clk_i); n++; end
    chk("rst_wr_tmo", {31'd0, n < 300}, 32'd1);
    @(posedge clk_i); #1;
    m1_aw_valid_i = 1'b0; m1_w_valid_i = 1'b0; rst_i = 1'b1;
    @(negedge clk_i);
    chk("wr_held", {31'd0, m1_aw_ready_o}, 32'd1);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("midrst_quiet", {20'd0, w_outs}, 32'd0);
    @(posedge clk_i); #1;
    last_m1 = 1'b1;
    for (int i = 0; i < 16; i++) ref_mem[i] = init_val(i);
    round(1, 1, 0, 4'd2, 4'd8, 4'd0, 32'd0, 4'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
